// File: rtl/sevenseg_scan.sv
`default_nettype none
// ============================================================================
// Module   : sevenseg_scan
// Brief    : Multiplexed 7-segment scanner with shadowed value/dp and LZ blanking.
// Revision : 1.0
// ============================================================================
module sevenseg_scan #(
    parameter int DIGITS     = 4,
    parameter int DIV        = 1000,
    parameter int HEX_EN     = 0,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    output logic [6:0]            segment,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  frame
);

    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PREW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PREW-1:0] c_pre_last = PREW'(DIV - 1);
    localparam logic [IDXW-1:0] c_idx_last = IDXW'(DIGITS - 1);
    localparam logic            c_inv      = (ACTIVE_LOW != 0);

    logic [PREW-1:0]       pre_q,   pre_d;
    logic [IDXW-1:0]       idx_q,   idx_d;
    logic [4*DIGITS-1:0]   val_q,   val_d;
    logic [DIGITS-1:0]     dp_q,    dp_d;
    logic                  wrap_q,  wrap_d;
    logic [6:0]            seg_q,   seg_d;
    logic                  dpo_q,   dpo_d;
    logic [DIGITS-1:0]     en_q,    en_d;
    logic                  frame_q, frame_d;

    logic                  w_pre_wrap;
    logic                  w_idx_last;
    logic [3:0]            w_nib;
    logic                  w_dp_sel;
    logic [DIGITS-1:0]     w_en;
    logic                  w_blank;
    logic                  w_zero_run;
    logic [6:0]            w_seg;

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] r;
        r = 7'b1000000;
        case (n)
            4'h0: r = 7'b0111111;
            4'h1: r = 7'b0000110;
            4'h2: r = 7'b1011011;
            4'h3: r = 7'b1001111;
            4'h4: r = 7'b1100110;
            4'h5: r = 7'b1101101;
            4'h6: r = 7'b1111101;
            4'h7: r = 7'b0000111;
            4'h8: r = 7'b1111111;
            4'h9: r = 7'b1101111;
            4'hA: r = (HEX_EN != 0) ? 7'b1110111 : 7'b1000000;
            4'hB: r = (HEX_EN != 0) ? 7'b1111100 : 7'b1000000;
            4'hC: r = (HEX_EN != 0) ? 7'b0111001 : 7'b1000000;
            4'hD: r = (HEX_EN != 0) ? 7'b1011110 : 7'b1000000;
            4'hE: r = (HEX_EN != 0) ? 7'b1111001 : 7'b1000000;
            4'hF: r = (HEX_EN != 0) ? 7'b1110001 : 7'b1000000;
            default: r = 7'b1000000;
        endcase
        return r;
    endfunction

    // Scan timing: prescaler, digit index and the end-of-frame marker.
    always_comb begin
        w_pre_wrap = (pre_q == c_pre_last);
        w_idx_last = (idx_q == c_idx_last);
        pre_d      = w_pre_wrap ? '0 : pre_q + PREW'(1);
        idx_d      = idx_q;
        if (w_pre_wrap) begin
            idx_d = w_idx_last ? '0 : idx_q + IDXW'(1);
        end
        wrap_d  = w_pre_wrap && w_idx_last;
        frame_d = wrap_q;
        val_d   = load ? value : val_q;
        dp_d    = load ? dp_in : dp_q;
    end

    // Digit select and leading-zero detection, walking from the most significant digit down.
    always_comb begin
        w_nib      = 4'd0;
        w_dp_sel   = 1'b0;
        w_en       = '0;
        w_blank    = 1'b0;
        w_zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_zero_run = w_zero_run & (val_q[4*i +: 4] == 4'd0);
            if (idx_q == IDXW'(i)) begin
                w_nib    = val_q[4*i +: 4];
                w_dp_sel = dp_q[i];
                w_en[i]  = 1'b1;
                w_blank  = blank_lz && w_zero_run && (i != 0);
            end
        end
        w_seg = w_blank ? 7'b0000000 : seg_decode(w_nib);
        seg_d = w_seg ^ {7{c_inv}};
        dpo_d = w_dp_sel ^ c_inv;
        en_d  = w_en ^ {DIGITS{c_inv}};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q   <= '0;
            idx_q   <= '0;
            val_q   <= '0;
            dp_q    <= '0;
            wrap_q  <= 1'b0;
            seg_q   <= {7{c_inv}};
            dpo_q   <= c_inv;
            en_q    <= {DIGITS{c_inv}};
            frame_q <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            val_q   <= val_d;
            dp_q    <= dp_d;
            wrap_q  <= wrap_d;
            seg_q   <= seg_d;
            dpo_q   <= dpo_d;
            en_q    <= en_d;
            frame_q <= frame_d;
        end
    end

    assign segment  = seg_q;
    assign dp_out   = dpo_q;
    assign digit_en = en_q;
    assign frame    = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_sevenseg_scan
// Brief    : Directed bench for sevenseg_scan across three parameter sets.
// Revision : 1.0
// ============================================================================
module tb_sevenseg_scan;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] value = 16'h0;
    logic        load = 1'b0;
    logic [3:0]  dp_in = 4'h0;
    logic        blank_lz = 1'b0;
    logic [3:0]  value2 = 4'h0;
    logic        load2 = 1'b0;
    logic        dp2 = 1'b0;

    logic [6:0]  seg0, seg1, seg2;
    logic        dp0, dp1, dpo2;
    logic [3:0]  en0, en1;
    logic        en2;
    logic        fr0, fr1, fr2;

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [6:0]  exp_seg [0:3];

    always #5 clk = ~clk;

    sevenseg_scan #(.DIGITS(4), .DIV(4), .HEX_EN(0), .ACTIVE_LOW(0)) u0 (
        .clk(clk), .reset(reset), .value(value), .load(load), .dp_in(dp_in),
        .blank_lz(blank_lz), .segment(seg0), .dp_out(dp0), .digit_en(en0), .frame(fr0)
    );

    sevenseg_scan #(.DIGITS(4), .DIV(4), .HEX_EN(1), .ACTIVE_LOW(1)) u1 (
        .clk(clk), .reset(reset), .value(value), .load(load), .dp_in(dp_in),
        .blank_lz(blank_lz), .segment(seg1), .dp_out(dp1), .digit_en(en1), .frame(fr1)
    );

    sevenseg_scan #(.DIGITS(1), .DIV(1), .HEX_EN(0), .ACTIVE_LOW(0)) u2 (
        .clk(clk), .reset(reset), .value(value2), .load(load2), .dp_in(dp2),
        .blank_lz(blank_lz), .segment(seg2), .dp_out(dpo2), .digit_en(en2), .frame(fr2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d got %0h exp %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    initial begin
        int d;
        exp_seg[0] = 7'h66;   // digit0 of 0x1234 -> 4
        exp_seg[1] = 7'h4F;   // 3
        exp_seg[2] = 7'h5B;   // 2
        exp_seg[3] = 7'h06;   // 1

        // Reset state
        repeat (3) tick();
        chk("rst_seg0", seg0, 7'h00);
        chk("rst_en0", en0, 4'h0);
        chk("rst_dp0", dp0, 1'b0);
        chk("rst_fr0", fr0, 1'b0);
        chk("rst_seg1", seg1, 7'h7F);
        chk("rst_en1", en1, 4'hF);
        chk("rst_dp1", dp1, 1'b1);
        chk("rst_fr1", fr1, 1'b0);
        chk("rst_en2", en2, 1'b0);
        chk("rst_fr2", fr2, 1'b0);

        // Release reset and load 0x1234 on the same edge
        cyc   = 0;
        reset = 1'b0;
        load  = 1'b1;
        value = 16'h1234;
        dp_in = 4'b1000;
        tick();
        load = 1'b0;
        chk("first_seg0", seg0, 7'h3F);
        chk("first_en0", en0, 4'h1);
        chk("first_fr0", fr0, 1'b0);
        chk("first_seg1", seg1, 7'h40);
        chk("first_en1", en1, 4'hE);
        chk("first_en2", en2, 1'b1);
        chk("first_fr2", fr2, 1'b0);
        chk("first_seg2", seg2, 7'h3F);

        // Full scans of 0x1234; single-digit instance loads 5 at edge 10
        for (int k = 2; k <= 33; k++) begin
            tick();
            d = ((k - 1) / 4) % 4;
            chk("scan_en", en0, 32'(1 << d));
            chk("scan_seg", seg0, exp_seg[d]);
            chk("scan_dp", dp0, (d == 3));
            chk("scan_frame", fr0, (k == 17 || k == 33));
            chk("u2_en", en2, 1'b1);
            chk("u2_frame", fr2, 1'b1);
            chk("u2_seg", seg2, (k <= 10) ? 7'h3F : 7'h6D);
            load2  = (k == 9);
            value2 = 4'h5;
        end

        // Hex / dash decode
        load  = 1'b1;
        value = 16'h00FA;
        tick();
        load = 1'b0;
        run_to(35);
        chk("hexA_dash", seg0, 7'h40);
        chk("hexA_glyph", seg1, 7'h08);
        chk("hexA_dp", dp0, 1'b0);
        run_to(37);
        chk("hexF_dash", seg0, 7'h40);
        chk("hexF_glyph", seg1, 7'h0E);
        chk("hexF_en1", en1, 4'hD);

        // Leading-zero blanking, loaded mid-frame
        load     = 1'b1;
        value    = 16'h0050;
        blank_lz = 1'b1;
        dp_in    = 4'b0100;
        tick();
        load = 1'b0;
        run_to(39);
        chk("lz_d1_seg", seg0, 7'h6D);
        chk("lz_d1_en", en0, 4'h2);
        run_to(41);
        chk("lz_d2_seg", seg0, 7'h00);
        chk("lz_d2_dp", dp0, 1'b1);
        chk("lz_d2_en", en0, 4'h4);
        run_to(45);
        chk("lz_d3_seg", seg0, 7'h00);
        chk("lz_d3_dp", dp0, 1'b0);
        run_to(49);
        chk("lz_d0_seg", seg0, 7'h3F);
        chk("lz_d0_frame", fr0, 1'b1);

        // All-zero value: only digit 0 lit
        load  = 1'b1;
        value = 16'h0000;
        tick();
        load = 1'b0;
        run_to(51);
        chk("z_d0_seg", seg0, 7'h3F);
        run_to(53);
        chk("z_d1_seg", seg0, 7'h00);
        chk("z_d1_seg1", seg1, 7'h7F);
        run_to(57);
        chk("z_d2_seg", seg0, 7'h00);
        chk("z_d2_dp", dp0, 1'b1);
        run_to(65);
        chk("z_d0b_seg", seg0, 7'h3F);
        chk("z_frame", fr0, 1'b1);

        // Active-low digit 0 showing 8
        load  = 1'b1;
        value = 16'h0008;
        dp_in = 4'h0;
        tick();
        load = 1'b0;
        run_to(67);
        chk("al8_seg1", seg1, 7'h00);
        chk("al8_en1", en1, 4'hE);
        chk("al8_seg0", seg0, 7'h7F);

        // Reset during index 2 together with load
        run_to(73);
        reset = 1'b1;
        load  = 1'b1;
        value = 16'h1234;
        tick();
        chk("mr_seg0", seg0, 7'h00);
        chk("mr_en0", en0, 4'h0);
        chk("mr_fr0", fr0, 1'b0);
        reset = 1'b0;
        load  = 1'b0;
        tick();
        chk("mr_first_seg", seg0, 7'h3F);
        chk("mr_first_en", en0, 4'h1);
        chk("mr_first_fr", fr0, 1'b0);
        chk("mr_first_fr2", fr2, 1'b0);
        tick();
        chk("mr_shadow_seg", seg0, 7'h3F);
        chk("mr_fr2", fr2, 1'b1);
        for (int k = 77; k <= 90; k++) begin
            tick();
            chk("mr_nofr", fr0, 1'b0);
        end
        tick();
        chk("mr_frame", fr0, 1'b1);
        chk("mr_frame_en", en0, 4'h1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
